// File: rtl/block_draw_sched_pkg.sv
// Shared definitions for the block-window draw scheduler.
// Holds the sprite geometry, the frame-start coordinates and the
// per-slot configuration record used by the top level and by the
// window matcher.
package block_draw_sched_pkg;

    localparam int BW         = 78;        // sprite width in pixels
    localparam int BH         = 53;        // sprite height in pixels
    localparam int SPRITE_PIX = BW * BH;   // pixels per sprite (4134)

    // Raster position at which shadow registers are committed.
    localparam int FRAME_H = 0;
    localparam int FRAME_V = 0;

    typedef struct packed {
        logic        en;
        logic        flash;
        logic [10:0] x;
        logic [9:0]  y;
        logic [1:0]  sprite;
        logic [7:0]  color;
    } slot_t;

endpackage

// File: rtl/block_win_match.sv
// Window compare and sprite offset for one block slot.
// Ports:
//   slot     - active configuration record of this slot
//   phase    - flash phase (frame counter bit 4)
//   hcount   - current horizontal pixel position
//   vcount   - current vertical line position
//   eligible - slot covers (hcount, vcount) and is visible this frame
//   offset   - (vcount-y)*BW + (hcount-x); only meaningful when eligible
module block_win_match #(
    parameter int BW = 78,
    parameter int BH = 53
) (
    input  block_draw_sched_pkg::slot_t slot,
    input  logic                        phase,
    input  logic [10:0]                 hcount,
    input  logic [9:0]                  vcount,
    output logic                        eligible,
    output logic [12:0]                 offset
);
    import block_draw_sched_pkg::*;

    logic [11:0] h12, v12, x_lo, x_hi, y_lo, y_hi, dx, dy;

    // 12-bit compare so that x+BW near the right edge cannot wrap.
    always_comb begin
        h12  = {1'b0, hcount};
        v12  = {2'b0, vcount};
        x_lo = {1'b0, slot.x};
        x_hi = x_lo + 12'(BW);
        y_lo = {2'b0, slot.y};
        y_hi = y_lo + 12'(BH);
        dx   = h12 - x_lo;
        dy   = v12 - y_lo;

        eligible = slot.en && !(slot.flash && phase) &&
                   (h12 >= x_lo) && (h12 < x_hi) &&
                   (v12 >= y_lo) && (v12 < y_hi);
        offset   = 13'(dy) * 13'(BW) + 13'(dx);
    end

endmodule

// File: rtl/block_draw_sched.sv
// Block-window draw scheduler: NSLOT on-screen windows share one sprite
// ROM. Configuration is written to shadow registers and committed to the
// active set at frame start; the lowest-index covering slot wins and its
// pixel is produced through a 3-stage pipeline around the ROM access.
// Ports:
//   vclk, rst          - pixel clock, async active-low reset
//   hcount, vcount     - raster position
//   cfg_*              - one-cycle shadow register write for slot cfg_slot
//   rom_sel, rom_addr  - shared ROM request (registered, stage 1)
//   rom_data           - ROM pixel code, one vclk after the request
//   pixel_out/hit      - composed pixel, 3 vclk after hcount/vcount
module block_draw_sched #(
    parameter int NSLOT = 4,
    parameter int BW    = 78,
    parameter int BH    = 53
) (
    input  logic        vclk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_slot,
    input  logic        cfg_en,
    input  logic        cfg_flash,
    input  logic [10:0] cfg_x,
    input  logic [9:0]  cfg_y,
    input  logic [1:0]  cfg_sprite,
    input  logic [7:0]  cfg_color,
    output logic [1:0]  rom_sel,
    output logic [12:0] rom_addr,
    input  logic [1:0]  rom_data,
    output logic [7:0]  pixel_out,
    output logic        pixel_hit
);
    import block_draw_sched_pkg::*;

    slot_t       shadow_q [NSLOT];
    slot_t       shadow_d [NSLOT];
    slot_t       active_q [NSLOT];
    slot_t       active_d [NSLOT];
    logic [7:0]  frame_q, frame_d;

    logic              commit;
    logic [NSLOT-1:0]  elig;
    logic [12:0]       offs [NSLOT];

    logic        win_hit;
    logic [1:0]  win_sprite;
    logic [7:0]  win_color;
    logic [12:0] win_offset;

    logic        s1_hit_q, s1_hit_d;
    logic [7:0]  s1_color_q, s1_color_d;
    logic [1:0]  rom_sel_q, rom_sel_d;
    logic [12:0] rom_addr_q, rom_addr_d;
    logic        s2_hit_q, s2_hit_d;
    logic [7:0]  s2_color_q, s2_color_d;
    logic [7:0]  pix_q, pix_d;
    logic        pix_hit_q, pix_hit_d;

    assign commit = (hcount == 11'(FRAME_H)) && (vcount == 10'(FRAME_V));

    for (genvar g = 0; g < NSLOT; g++) begin : g_match
        block_win_match #(
            .BW (BW),
            .BH (BH)
        ) u_match (
            .slot     (active_q[g]),
            .phase    (frame_q[4]),
            .hcount   (hcount),
            .vcount   (vcount),
            .eligible (elig[g]),
            .offset   (offs[g])
        );
    end

    // Shadow write and commit. The commit copies shadow_q, so a write on
    // the commit edge lands in the shadow only and shows a frame later.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        frame_d  = frame_q;
        for (int i = 0; i < NSLOT; i++) begin
            if (cfg_we && (cfg_slot == 2'(i))) begin
                shadow_d[i] = '{en: cfg_en, flash: cfg_flash, x: cfg_x,
                                y: cfg_y, sprite: cfg_sprite,
                                color: cfg_color};
            end
        end
        if (commit) begin
            active_d = shadow_q;
            frame_d  = frame_q + 8'd1;
        end
    end

    // Fixed priority: scan downward so the lowest eligible index wins.
    always_comb begin
        win_hit    = 1'b0;
        win_sprite = 2'b00;
        win_color  = 8'h00;
        win_offset = 13'd0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_hit    = 1'b1;
                win_sprite = active_q[i].sprite;
                win_color  = active_q[i].color;
                win_offset = offs[i];
            end
        end
    end

    always_comb begin
        s1_hit_d   = win_hit;
        s1_color_d = win_color;
        rom_sel_d  = win_sprite;
        rom_addr_d = win_offset;
        s2_hit_d   = s1_hit_q;
        s2_color_d = s1_color_q;
        pix_d      = 8'h00;
        pix_hit_d  = 1'b0;
        if (s2_hit_q && (rom_data != 2'b00)) begin
            pix_hit_d = 1'b1;
            pix_d     = (rom_data == 2'b11) ? 8'hFF : s2_color_q;
        end
    end

    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            frame_q    <= 8'd0;
            s1_hit_q   <= 1'b0;
            s1_color_q <= 8'h00;
            rom_sel_q  <= 2'b00;
            rom_addr_q <= 13'd0;
            s2_hit_q   <= 1'b0;
            s2_color_q <= 8'h00;
            pix_q      <= 8'h00;
            pix_hit_q  <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            frame_q    <= frame_d;
            s1_hit_q   <= s1_hit_d;
            s1_color_q <= s1_color_d;
            rom_sel_q  <= rom_sel_d;
            rom_addr_q <= rom_addr_d;
            s2_hit_q   <= s2_hit_d;
            s2_color_q <= s2_color_d;
            pix_q      <= pix_d;
            pix_hit_q  <= pix_hit_d;
        end
    end

    assign rom_sel   = rom_sel_q;
    assign rom_addr  = rom_addr_q;
    assign pixel_out = pix_q;
    assign pixel_hit = pix_hit_q;

endmodule

// File: tb/tb_block_draw_sched.sv
module tb_block_draw_sched;

    localparam int BLANK_H = 2000;
    localparam int BLANK_V = 1000;

    logic        vclk;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        cfg_we;
    logic [1:0]  cfg_slot;
    logic        cfg_en;
    logic        cfg_flash;
    logic [10:0] cfg_x;
    logic [9:0]  cfg_y;
    logic [1:0]  cfg_sprite;
    logic [7:0]  cfg_color;
    logic [1:0]  rom_sel;
    logic [12:0] rom_addr;
    logic [1:0]  rom_data;
    logic [7:0]  pixel_out;
    logic        pixel_hit;

    int checks = 0;
    int errors = 0;
    int fcnt   = 0;

    // Sprite ROM: sprite 0 -> transparent, 1 -> 11, 2 -> 01, 3 -> 10.
    logic [1:0] rom_tab [4];

    block_draw_sched dut (
        .vclk       (vclk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .cfg_we     (cfg_we),
        .cfg_slot   (cfg_slot),
        .cfg_en     (cfg_en),
        .cfg_flash  (cfg_flash),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_sprite (cfg_sprite),
        .cfg_color  (cfg_color),
        .rom_sel    (rom_sel),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pixel_out  (pixel_out),
        .pixel_hit  (pixel_hit)
    );

    initial vclk = 1'b0;
    always #5 vclk = ~vclk;

    always @(posedge vclk) rom_data <= rom_tab[rom_sel];

    task automatic tick();
        @(posedge vclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int slot, input bit en, input bit fl,
                       input int x, input int y, input int spr,
                       input int col);
        cfg_slot   = 2'(slot);
        cfg_en     = en;
        cfg_flash  = fl;
        cfg_x      = 11'(x);
        cfg_y      = 10'(y);
        cfg_sprite = 2'(spr);
        cfg_color  = 8'(col);
        cfg_we     = 1'b1;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic frame_start();
        hcount = 11'd0;
        vcount = 10'd0;
        tick();
        fcnt   = (fcnt + 1) % 256;
        hcount = 11'(BLANK_H);
        vcount = 10'(BLANK_V);
    endtask

    task automatic advance_to(input int n);
        while (fcnt != n) frame_start();
    endtask

    // Present one coordinate for a single cycle, check the ROM request one
    // vclk later and the composed pixel exactly three vclk later.
    task automatic probe(input string tag, input int h, input int v,
                         input int esel, input int eaddr,
                         input int epix, input int ehit);
        hcount = 11'(h);
        vcount = 10'(v);
        tick();
        chk({tag, "_sel"}, 32'(rom_sel), 32'(esel));
        chk({tag, "_addr"}, 32'(rom_addr), 32'(eaddr));
        hcount = 11'(BLANK_H);
        vcount = 10'(BLANK_V);
        tick();
        chk({tag, "_early"}, 32'(pixel_hit), 32'd0);
        tick();
        chk({tag, "_pix"}, 32'(pixel_out), 32'(epix));
        chk({tag, "_hit"}, 32'(pixel_hit), 32'(ehit));
    endtask

    initial begin
        rom_tab[0] = 2'b00;
        rom_tab[1] = 2'b11;
        rom_tab[2] = 2'b01;
        rom_tab[3] = 2'b10;
        rst        = 1'b0;
        hcount     = 11'(BLANK_H);
        vcount     = 10'(BLANK_V);
        cfg_we     = 1'b0;
        cfg_slot   = 2'd0;
        cfg_en     = 1'b0;
        cfg_flash  = 1'b0;
        cfg_x      = 11'd0;
        cfg_y      = 10'd0;
        cfg_sprite = 2'd0;
        cfg_color  = 8'h00;
        #2;
        chk("rst_sel", 32'(rom_sel), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_pix", 32'(pixel_out), 32'd0);
        chk("rst_hit", 32'(pixel_hit), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single window, sprite 1 returns 11.
        cfg(0, 1, 0, 551, 466, 1, 8'h55);
        probe("precommit", 551, 466, 0, 0, 8'h00, 0);
        frame_start();
        probe("single_tl", 551, 466, 1, 0, 8'hFF, 1);
        probe("single_br", 628, 518, 1, 4133, 8'hFF, 1);
        probe("edge_right", 629, 518, 0, 0, 8'h00, 0);
        probe("edge_bottom", 628, 519, 0, 0, 8'h00, 0);
        probe("edge_left", 550, 466, 0, 0, 8'h00, 0);

        // Overlap: slot0 beats slot2.
        cfg(0, 1, 0, 551, 466, 2, 8'hCF);
        cfg(2, 1, 0, 551, 466, 2, 8'h1C);
        frame_start();
        probe("overlap0", 600, 480, 2, 1141, 8'hCF, 1);
        cfg(0, 0, 0, 551, 466, 2, 8'hCF);
        probe("overlap_pend", 600, 480, 2, 1141, 8'hCF, 1);
        frame_start();
        probe("overlap2", 600, 480, 2, 1141, 8'h1C, 1);

        // Commit timing on slot1.
        cfg(1, 1, 0, 100, 100, 3, 8'h33);
        frame_start();
        probe("c_base", 100, 100, 3, 0, 8'h33, 1);
        cfg(1, 1, 0, 100, 100, 3, 8'h44);
        probe("c_midframe", 101, 100, 3, 1, 8'h33, 1);
        frame_start();
        probe("c_next", 101, 101, 3, 79, 8'h44, 1);
        hcount = 11'd0;
        vcount = 10'd0;
        cfg(1, 1, 0, 100, 100, 3, 8'h66);
        fcnt   = (fcnt + 1) % 256;
        hcount = 11'(BLANK_H);
        vcount = 10'(BLANK_V);
        probe("c_coincide", 100, 100, 3, 0, 8'h44, 1);
        frame_start();
        probe("c_later", 100, 100, 3, 0, 8'h66, 1);

        // Flash on slot0 at (300,200).
        cfg(0, 1, 1, 300, 200, 3, 8'hAA);
        frame_start();
        probe("fl_8", 300, 200, 3, 0, 8'hAA, 1);
        advance_to(15);
        probe("fl_15", 300, 200, 3, 0, 8'hAA, 1);
        advance_to(16);
        probe("fl_16", 300, 200, 0, 0, 8'h00, 0);
        advance_to(31);
        probe("fl_31", 300, 200, 0, 0, 8'h00, 0);
        advance_to(32);
        probe("fl_32", 300, 200, 3, 0, 8'hAA, 1);
        advance_to(47);
        probe("fl_47", 300, 200, 3, 0, 8'hAA, 1);
        advance_to(48);
        probe("fl_48", 300, 200, 0, 0, 8'h00, 0);
        advance_to(255);
        probe("fl_255", 300, 200, 0, 0, 8'h00, 0);
        frame_start();
        probe("fl_wrap0", 300, 200, 3, 0, 8'hAA, 1);

        // Transparency and blanking.
        cfg(3, 1, 0, 800, 300, 0, 8'h77);
        frame_start();
        probe("transp", 810, 310, 0, 790, 8'h00, 0);
        probe("blank", 1000, 500, 0, 0, 8'h00, 0);

        // Reset mid-window.
        hcount = 11'd100;
        vcount = 10'd100;
        tick();
        tick();
        tick();
        chk("pre_rst_hit", 32'(pixel_hit), 32'd1);
        rst = 1'b0;
        #2;
        chk("mrst_sel", 32'(rom_sel), 32'd0);
        chk("mrst_addr", 32'(rom_addr), 32'd0);
        chk("mrst_pix", 32'(pixel_out), 32'd0);
        chk("mrst_hit", 32'(pixel_hit), 32'd0);
        fcnt = 0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_sel", 32'(rom_sel), 32'd0);
        chk("post_rst_hit", 32'(pixel_hit), 32'd0);
        hcount = 11'(BLANK_H);
        vcount = 10'(BLANK_V);
        frame_start();
        probe("post_rst_frame", 100, 100, 0, 0, 8'h00, 0);
        cfg(1, 1, 0, 100, 100, 3, 8'h5A);
        frame_start();
        probe("post_rst_cfg", 100, 100, 3, 0, 8'h5A, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_draw_sched.md
BLOCK_DRAW_SCHED -- requirements
Module: block_draw_sched

Interface
REQ-001 Parameter NSLOT, default 4: number of on-screen block windows sharing one sprite ROM.
REQ-002 Parameter BW, default 78: sprite width in pixels.
REQ-003 Parameter BH, default 53: sprite height in pixels.
REQ-004 Ports, in this order:
- vclk  in  1: pixel clock; the only clock.
- rst  in  1: reset, asynchronous, active-low.
- hcount  in  11: current horizontal pixel position.
- vcount  in  10: current vertical line position.
- cfg_we  in  1: configuration write strobe, one cycle.
- cfg_slot  in  2: slot being written.
- cfg_en  in  1: slot enable.
- cfg_flash  in  1: slot flashes when set.
- cfg_x  in  11: window left edge.
- cfg_y  in  10: window top edge.
- cfg_sprite  in  2: sprite selector.
- cfg_color  in  8: colour for ROM codes 01 and 10.
- rom_sel  out  2: sprite selector to the shared ROM.
- rom_addr  out  13: pixel offset to the shared ROM.
- rom_data  in  2: ROM pixel code, valid one vclk after rom_sel/rom_addr.
- pixel_out  out  8: composed pixel colour.
- pixel_hit  out  1: pixel_out is opaque block content.

Function
REQ-005 Each slot SHALL hold shadow registers and active registers: en, flash, x, y, sprite, color.
REQ-006 A cfg_we pulse SHALL write the shadow registers of slot cfg_slot on that edge; cfg_we is always accepted and has no ready handshake.
REQ-007 Shadow-to-active commit SHALL occur on the edge where hcount==0 and vcount==0.
REQ-008 If cfg_we coincides with the commit edge, the commit SHALL use the pre-write shadow values, and the new write SHALL take effect at the next frame.
REQ-009 An 8-bit frame counter SHALL increment on each commit edge and wrap from 255 to 0.
REQ-010 Flash phase SHALL be frame counter bit 4, i.e. it toggles every 16 frames.
REQ-011 Slot i SHALL be eligible at (hcount, vcount) when all of the following hold:
- en=1;
- not (flash=1 and phase=1);
- x <= hcount < x+BW;
- y <= vcount < y+BH.
- Compare arithmetic is 12-bit, so x+BW does not wrap.
REQ-012 If several slots are eligible, the lowest index SHALL win (fixed priority).
REQ-013 Offset SHALL be (vcount-y)*BW + (hcount-x), computed at 13 bits; the maximum is BW*BH-1 = 4133.
REQ-014 Pipeline timing:
- Stage 1 registers the winner, hit and offset; rom_sel = winner sprite and rom_addr = offset, both registered one vclk after hcount/vcount.
- Stage 2 carries the winner colour and hit alongside the ROM access.
- Stage 3 registers pixel_out/pixel_hit.
- Total latency from hcount/vcount to pixel_out SHALL be 3 vclk.
REQ-015 When there is no winner, rom_sel and rom_addr SHALL be 0, and stage 3 SHALL output pixel_out=8'h00 and pixel_hit=0.
REQ-016 With a winner, stage 3 SHALL map rom_data as follows:
- 00 -> transparent: pixel_out=8'h00, pixel_hit=0.
- 11 -> pixel_out=8'hFF, pixel_hit=1.
- 01 or 10 -> pixel_out=winner color, pixel_hit=1.
REQ-017 The colour used SHALL be the active colour captured at stage 1, so that a commit mid-pipeline does not tear a pixel.
REQ-018 Out-of-range hcount/vcount (blanking) SHALL simply produce no winner; no special state is required.

Reset
REQ-019 While rst=0, asynchronously:
- all shadow and active registers SHALL be 0 (every slot disabled);
- the frame counter SHALL be 0;
- all pipeline stages SHALL be cleared: rom_sel=0, rom_addr=0, pixel_out=8'h00, pixel_hit=0.
REQ-020 After rst rises, the first commit edge SHALL be the first frame start; in-flight pipeline data SHALL be discarded on reset mid-frame.

Structure
REQ-021 A shared package SHALL hold:
- the constants BW, BH, SPRITE_PIX (BW*BH) and the screen frame-start coordinates;
- the slot-record typedef (en, flash, x, y, sprite, color).
REQ-022 One sub-module, block_win_match, SHALL perform the per-slot window compare and offset computation; it is instantiated NSLOT times.
REQ-023 Arbitration, the pipeline and the palette SHALL live in block_draw_sched.

Verification
REQ-024 Required directed scenarios:
- Single window: slot0 en, x=551, y=466, sprite=1; ROM returns 11 -> at hcount=551, vcount=466, rom_addr=0 and rom_sel=1 after 1 vclk; pixel_out=FF with hit=1 after 3 vclk. At (628,518), rom_addr=4133.
- Overlap: slot0 and slot2 cover the same area with colours 0xCF and 0x1C; ROM returns 01 -> pixel_out=CF (slot0 wins). With slot0 disabled -> pixel_out=1C.
- Commit timing: write slot1 colour 0x33 mid-frame -> old colour persists until hcount=0/vcount=0; a write on exactly that edge appears one frame later.
- Flash: slot0 flash=1 -> hidden for frames 16-31 of the counter, visible for 0-15 and 32-47; counter wraps 255 -> 0.
- Transparency and blanking: ROM code 00 inside a window -> pixel_out=00, hit=0; vcount=500 -> rom_addr=0, hit=0.
- Reset: rst low mid-window -> all outputs 0 immediately; after release, no hit until the next frame start plus config.
